// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM; in Opcode/mem_ready, out datapath controls, ALUop, done/illegal/timeout pulses, state_o
module mips_multicycle_control #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state, nxt;
  logic [7:0] cnt;
  logic last;
  assign last = cnt == 8'(WAIT_LIMIT - 1);
  assign state_o = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt == state) ? cnt + 8'd1 : '0;
    end
  end
  always_comb begin
    {PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
     ALUSrcA, ALUSrcB, ALUop, instr_done, illegal_op, mem_timeout} = '0;
    nxt = IDLE;
    case (state)
      IDLE: nxt = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        mem_timeout = !mem_ready && last;
        nxt = mem_ready ? DECODE : (last ? IDLE : FETCH);
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        nxt = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
              (Opcode == OP_R)    ? EXECUTE :
              (Opcode == OP_BEQ)  ? BRANCH  :
              (Opcode == OP_ADDI) ? ADDIEX  :
              (Opcode == OP_J)    ? JUMP    : FETCH;
        illegal_op = nxt == FETCH;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        mem_timeout = !mem_ready && last;
        nxt = mem_ready ? MEMWB : (last ? IDLE : MEMREAD);
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        instr_done = mem_ready;
        mem_timeout = !mem_ready && last;
        nxt = mem_ready ? FETCH : (last ? IDLE : MEMWRITE);
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUop = 3'b001;
        nxt = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUop = 3'b010;
        Branch = 1'b1;
        PCSrc = 2'b01;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc = 2'b10;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
